// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes, field positions and EPC helper
package cp0_pkg;
  localparam logic [4:0] CP0_SR = 5'd12, CP0_CAUSE = 5'd13, CP0_EPC = 5'd14, CP0_PRID = 5'd15;
  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10, EXC_OV = 5'd12;
  localparam int IM_LO = 10, EXL_BIT = 1, IE_BIT = 0, BD_BIT = 31, IP_LO = 10, EXC_LO = 2;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  // Word address of the restart PC: a delay-slot instruction restarts at its branch
  function automatic logic [29:0] epc_of(input logic [31:0] pc, input logic bd);
    return 30'((bd ? pc - 32'd4 : pc) >> 2);
  endfunction
endpackage

// File: rtl/cp0_int_arb.sv
// cp0_int_arb: interrupt/exception request and ExcCode priority selection
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] m_exc_code,
  output logic       req,
  output logic [4:0] exc_code
);
  logic int_req, exc_req;
  assign int_req  = ie & ~exl & |(hw_int & im);
  assign exc_req  = ~exl & (m_exc_code != 5'd0);
  assign req      = int_req | exc_req;
  assign exc_code = int_req ? EXC_INT : m_exc_code;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 holding SR/Cause/EPC/PRId, raising the M-stage exception request
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2021_0007,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_bd,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic        req
);
  logic [5:0] im, ip;
  logic exl, ie, bd;
  logic [4:0] exc, sel_code;
  logic [29:0] epc;
  logic [31:0] sr_w, cause_w;
  cp0_int_arb u_arb (
    .ie(ie), .exl(exl), .im(im), .hw_int(hw_int), .m_exc_code(m_exc_code),
    .req(req), .exc_code(sel_code)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= IM_RESET;
      exl <= 1'b0;
      ie  <= 1'b0;
      bd  <= 1'b0;
      ip  <= '0;
      exc <= '0;
      epc <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl <= 1'b1;
        bd  <= m_bd;
        exc <= sel_code;
        epc <= epc_of(m_pc, m_bd);
      end else begin
        if (en && cp0_addr == CP0_SR) begin
          im  <= cp0_din[IM_LO+:6];
          ie  <= cp0_din[IE_BIT];
          exl <= exl_clr ? 1'b0 : cp0_din[EXL_BIT];
        end else if (exl_clr) exl <= 1'b0;
        if (en && cp0_addr == CP0_EPC) epc <= cp0_din[31:2];
      end
    end
  end
  always_comb begin
    sr_w = '0;
    sr_w[IM_LO+:6] = im;
    sr_w[EXL_BIT] = exl;
    sr_w[IE_BIT] = ie;
    cause_w = '0;
    cause_w[BD_BIT] = bd;
    cause_w[IP_LO+:6] = ip;
    cause_w[EXC_LO+:5] = exc;
  end
  assign epc_out  = {epc, 2'b00};
  assign cp0_dout = cp0_addr == CP0_SR    ? sr_w    :
                    cp0_addr == CP0_CAUSE ? cause_w :
                    cp0_addr == CP0_EPC   ? epc_out :
                    cp0_addr == CP0_PRID  ? PRID    : 32'd0;
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline. Sits at the M stage and is the source of the exception/interrupt request `req` that flushes the F/D, D/E, E/M and M/W pipeline registers.
- Holds SR, Cause, EPC and PRId. Services mfc0/mtc0 and eret.
- Prioritises hardware interrupts against the synchronous exception code carried down the pipe.
- Supplies EPC to the F-stage PC mux for eret.

Parameters:
- PRID, 32'h2021_0007, read-only value of PRId (reg 15).
- IM_RESET, 6'b000000, reset value of SR.IM.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- en  in  1  mtc0 write enable (M stage).
- cp0_addr  in  5  CP0 register number for mfc0/mtc0.
- cp0_din  in  32  mtc0 write data (forwarded rt).
- m_pc  in  32  PC of the instruction currently in M.
- m_exc_code  in  5  accumulated exception code in M; 0 means none.
- m_bd  in  1  M instruction is in a branch delay slot.
- hw_int  in  6  external interrupt lines [5:0] (timer0, timer1, interrupt generator, ...).
- exl_clr  in  1  eret in M.
- cp0_dout  out  32  mfc0 read data.
- epc_out  out  32  current EPC value.
- req  out  1  take-exception pulse to all pipeline registers and the PC.

Behaviour:
- Field layout:
  - SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC: full 32 bits, bits[1:0] forced 0.
- Reset (synchronous): SR.IM=IM_RESET, EXL=0, IE=0; Cause=0; EPC=0. Outputs then give req=0, epc_out=0.
- Combinational request:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (m_exc_code != 0).
  - req = int_req | exc_req, combinational, same cycle, no latency.
- Priority: when both are pending, the interrupt wins and ExcCode records 0.
- On posedge clk with req=1:
  - EXL<=1.
  - Cause.BD<=m_bd.
  - Cause.ExcCode <= int_req ? 5'd0 : m_exc_code.
  - EPC <= (m_bd ? m_pc-4 : m_pc) & ~3.
  - Pipeline registers concurrently load the handler PC 32'h0000_4180.
- Cause.IP <= hw_int every cycle, unconditionally, including while EXL=1. IP is not masked.
- mtc0 (en=1, req=0):
  - addr 12 writes SR: only IM, EXL and IE are stored.
  - addr 14 writes EPC with bits[1:0]=0.
  - addr 13 and 15 are ignored; Cause and PRId are read-only.
  - If en=1 and req=1 in the same cycle, the write is dropped (the instruction was cancelled).
- eret (exl_clr=1):
  - EXL<=0 at the edge.
  - If req=1 in the same cycle, req takes priority and EXL<=1. This cannot normally occur because req requires EXL=0.
  - exl_clr together with an SR mtc0 in the same cycle: exl_clr wins for the EXL bit.
- While EXL=1: req is held at 0 regardless of hw_int or m_exc_code. Nested exceptions are not taken.
- Reads:
  - cp0_dout is combinational on cp0_addr: 12 SR, 13 Cause, 14 EPC, 15 PRID, others 0.
  - Reads return pre-write (registered) values.
  - epc_out is always the registered EPC. The pipeline stalls eret in D behind an mtc0 EPC in E/M.
- Width rules: m_pc-4 is 32-bit modular; m_pc=0 with BD gives 32'hFFFF_FFFC.

Decomposition:
- Shared package `cp0_pkg`:
  - register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15;
  - ExcCode constants INT=0, ADEL=4, ADES=5, RI=10, OV=12;
  - field bit positions;
  - handler address 32'h0000_4180.
- One natural sub-module: `cp0_int_arb`, combinational request/priority logic producing int_req, exc_req, req and the selected ExcCode.

Test Plan:
- Reset, then mfc0 15 -> cp0_dout=PRID. mfc0 12/13/14 -> 0. req=0.
- mtc0 12 with 32'h0000_FC01, then hw_int=6'b000100 -> req=1 in the same cycle. Next cycle: Cause=32'h0000_1000, EXL=1, EPC=m_pc & ~3, req=0.
- m_exc_code=12 (Ov), m_bd=1, m_pc=32'h0000_3010, IE=0 -> req=1. Next cycle: EPC=32'h0000_300C, Cause.BD=1, ExcCode=12.
- Simultaneous enabled interrupt and m_exc_code=4 -> ExcCode=0. Same cycle en=1 to EPC -> write dropped; EPC=m_pc.
- With EXL=1, assert hw_int and m_exc_code=10 -> req stays 0. Apply exl_clr -> EXL=0 next cycle; pending interrupt raises req immediately after.
- mtc0 13 with 32'hFFFF_FFFF -> Cause unchanged. mtc0 14 with 32'h0000_3007 -> epc_out=32'h0000_3004. Reset mid-handler (EXL=1) -> all registers cleared next edge.
